// File: rtl/inj_local_port_arbiter.sv
// inj_local_port_arbiter: round-robin share of one router Local input port
// between NUM_REQ injectors over the Req/Gnt/Full handshake.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   ReqUpStr       per-injector send request (bit i = injector i)
//   PacketIn       injector packets, slice i = [i*packetwidth +: packetwidth]
//   GntUpStr       one-hot, one-cycle grant back to the winning injector
//   UpStrFull      router full, broadcast to every injector
//   ReqDnStr       request to the router Local port
//   GntDnStr       grant from the router Local port
//   DnStrFull      router Local FIFO full
//   PacketOut      latched packet presented to the router
//   Winner         index of the current or last selected injector
//   Busy           high whenever a packet is in flight or being granted
module inj_local_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int packetwidth = 56,
    parameter int IDXW        = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             ReqUpStr,
    input  logic [NUM_REQ*packetwidth-1:0] PacketIn,
    output logic [NUM_REQ-1:0]             GntUpStr,
    output logic                           UpStrFull,
    output logic                           ReqDnStr,
    input  logic                           GntDnStr,
    input  logic                           DnStrFull,
    output logic [packetwidth-1:0]         PacketOut,
    output logic [IDXW-1:0]                Winner,
    output logic                           Busy
);

    typedef enum logic [1:0] {IDLE, WAIT_DN, GNT_UP} state_t;

    state_t                 state, stateNext;
    logic [NUM_REQ-1:0]     gntNext;
    logic                   reqNext;
    logic [packetwidth-1:0] pktNext;
    logic [IDXW-1:0]        winNext, ptr, ptrNext, pickIdx;
    logic                   pickFound;
    int                     cand;

    assign UpStrFull = DnStrFull;
    assign Busy      = (state != IDLE);

    // First requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        pickIdx   = '0;
        pickFound = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!pickFound && ReqUpStr[cand]) begin
                pickFound = 1'b1;
                pickIdx   = IDXW'(cand);
            end
        end
    end

    always_comb begin
        stateNext = state;
        gntNext   = GntUpStr;
        reqNext   = ReqDnStr;
        pktNext   = PacketOut;
        winNext   = Winner;
        ptrNext   = ptr;
        case (state)
            IDLE: if (pickFound && !DnStrFull) begin
                winNext   = pickIdx;
                pktNext   = PacketIn[int'(pickIdx)*packetwidth +: packetwidth];
                reqNext   = 1'b1;
                stateNext = WAIT_DN;
            end
            WAIT_DN: if (GntDnStr) begin
                reqNext   = 1'b0;
                gntNext   = NUM_REQ'(1) << Winner;
                ptrNext   = (Winner == IDXW'(NUM_REQ - 1)) ? '0 : Winner + 1'b1;
                stateNext = GNT_UP;
            end
            GNT_UP: begin
                // Grant lasts exactly one cycle, giving the winner an edge
                // to drop its request before the next arbitration.
                gntNext   = '0;
                stateNext = IDLE;
            end
            default: begin
                gntNext   = '0;
                reqNext   = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            GntUpStr  <= '0;
            ReqDnStr  <= 1'b0;
            PacketOut <= '0;
            Winner    <= '0;
            ptr       <= '0;
        end else begin
            state     <= stateNext;
            GntUpStr  <= gntNext;
            ReqDnStr  <= reqNext;
            PacketOut <= pktNext;
            Winner    <= winNext;
            ptr       <= ptrNext;
        end
    end

endmodule

// File: tb/tb_inj_local_port_arbiter.sv
// tb_inj_local_port_arbiter: directed and random checks of the local port
// arbiter against a transaction-level reference model.
module tb_inj_local_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int PW      = 56;
    localparam int IDXW    = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NUM_REQ-1:0]     ReqUpStr = '0;
    logic [NUM_REQ*PW-1:0]  PacketIn = '0;
    logic [NUM_REQ-1:0]     GntUpStr;
    logic                   UpStrFull;
    logic                   ReqDnStr;
    logic                   GntDnStr = 1'b0;
    logic                   DnStrFull = 1'b0;
    logic [PW-1:0]          PacketOut;
    logic [IDXW-1:0]        Winner;
    logic                   Busy;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: whether a packet is outstanding, whether the grant
    // pulse is due, round-robin start point and the held packet.
    bit            mInFlight, mGrantCycle;
    int            mPtr, mWin;
    logic [PW-1:0] mPkt;

    inj_local_port_arbiter #(.NUM_REQ(NUM_REQ), .packetwidth(PW), .IDXW(IDXW)) dut (
        .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
        .GntUpStr(GntUpStr), .UpStrFull(UpStrFull), .ReqDnStr(ReqDnStr),
        .GntDnStr(GntDnStr), .DnStrFull(DnStrFull), .PacketOut(PacketOut),
        .Winner(Winner), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mInFlight = 0; mGrantCycle = 0; mPtr = 0; mWin = 0; mPkt = '0;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge
    task automatic modelEdge();
        if (!reset) modelReset();
        else if (mGrantCycle) mGrantCycle = 0;
        else if (mInFlight) begin
            if (GntDnStr) begin
                mInFlight = 0; mGrantCycle = 1; mPtr = (mWin + 1) % NUM_REQ;
            end
        end else if (ReqUpStr != 0 && !DnStrFull) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c = (mPtr + k) % NUM_REQ;
                if (ReqUpStr[c]) begin
                    mWin = c; mPkt = PacketIn[c*PW +: PW]; mInFlight = 1;
                    break;
                end
            end
        end
    endtask

    task automatic checkModel();
        check("ReqDnStr", 64'(ReqDnStr), 64'(mInFlight));
        check("GntUpStr", 64'(GntUpStr), mGrantCycle ? 64'(1) << mWin : 64'd0);
        check("PacketOut", 64'(PacketOut), 64'(mPkt));
        check("Winner", 64'(Winner), 64'(mWin));
        check("Busy", 64'(Busy), 64'(mInFlight | mGrantCycle));
        check("UpStrFull", 64'(UpStrFull), 64'(DnStrFull));
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    int order[$];
    int rises[$];
    int expOrder[5] = '{0, 1, 2, 3, 0};
    logic prevReq;
    logic [PW-1:0] oldPkt;

    initial begin
        modelReset();
        tick();
        tick();
        @(negedge clk) reset = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_req", 64'(ReqDnStr), 0);
            check("t1_gnt", 64'(GntUpStr), 0);
            check("t1_pkt", 64'(PacketOut), 0);
            check("t1_busy", 64'(Busy), 0);
        end

        // Single requester 2, router grants two cycles after request
        ReqUpStr = 4'b0100;
        PacketIn[2*PW +: PW] = 56'hABC;
        tick();
        check("t2_req", 64'(ReqDnStr), 1);
        check("t2_pkt", 64'(PacketOut), 56'hABC);
        check("t2_win", 64'(Winner), 2);
        tick();
        GntDnStr = 1'b1;
        tick();
        check("t2_gnt", 64'(GntUpStr), 4'b0100);
        GntDnStr = 1'b0;
        ReqUpStr = 4'b0000;
        tick();
        check("t2_gnt_off", 64'(GntUpStr), 0);
        // ptr is now 3: requester 3 must beat requester 0
        ReqUpStr = 4'b1001;
        tick();
        check("t2_ptr3", 64'(Winner), 3);
        GntDnStr = 1'b1;
        tick();
        GntDnStr = 1'b0;
        ReqUpStr = 4'b0000;
        tick();

        // All requesting, immediate grants: order 0,1,2,3,0
        ReqUpStr = 4'b1111;
        GntDnStr = 1'b1;
        prevReq = ReqDnStr;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (GntUpStr != 0) order.push_back(int'(Winner));
            if (ReqDnStr && !prevReq) rises.push_back(i);
            prevReq = ReqDnStr;
        end
        GntDnStr = 1'b0;
        ReqUpStr = 4'b0000;
        check("t3_count", 64'(order.size()), 5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("t3_order", 64'(order[i]), 64'(expOrder[i]));
        for (int i = 1; i < rises.size(); i++) check("t3_gap", 64'(rises[i] - rises[i-1]), 3);
        tick();
        tick();

        // Router full blocks selection
        DnStrFull = 1'b1;
        ReqUpStr = 4'b0010;
        PacketIn[1*PW +: PW] = 56'h1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_blocked", 64'(ReqDnStr), 0);
            check("t4_full", 64'(UpStrFull), 1);
        end
        DnStrFull = 1'b0;
        tick();
        check("t4_req", 64'(ReqDnStr), 1);
        check("t4_win", 64'(Winner), 1);

        // Inputs changing in WAIT_DN are ignored
        oldPkt = PacketOut;
        PacketIn[1*PW +: PW] = 56'h2222;
        ReqUpStr = 4'b1010;
        DnStrFull = 1'b1;
        tick();
        tick();
        check("t5_frozen", 64'(PacketOut), 64'(oldPkt));
        DnStrFull = 1'b0;
        GntDnStr = 1'b1;
        tick();
        check("t5_gnt", 64'(GntUpStr), 4'b0010);
        GntDnStr = 1'b0;
        ReqUpStr = 4'b1000;
        tick();
        check("t5_gap", 64'(ReqDnStr), 0);
        tick();
        check("t5_win3", 64'(Winner), 3);
        check("t5_req3", 64'(ReqDnStr), 1);

        // Asynchronous reset mid-transaction
        #2 reset = 1'b0;
        #1;
        modelReset();
        check("t6_req", 64'(ReqDnStr), 0);
        check("t6_gnt", 64'(GntUpStr), 0);
        check("t6_busy", 64'(Busy), 0);
        GntDnStr = 1'b1;
        tick();
        check("t6_no_gnt", 64'(GntUpStr), 0);
        GntDnStr = 1'b0;
        ReqUpStr = 4'b1111;
        @(negedge clk) reset = 1'b1;
        tick();
        check("t6_restart", 64'(Winner), 0);
        ReqUpStr = 4'b0000;
        GntDnStr = 1'b1;
        tick();
        GntDnStr = 1'b0;
        tick();

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            ReqUpStr  = NUM_REQ'($urandom);
            for (int j = 0; j < NUM_REQ; j++) PacketIn[j*PW +: PW] = {$urandom, $urandom};
            DnStrFull = ($urandom_range(3) == 0);
            GntDnStr  = $urandom_range(1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/inj_local_port_arbiter.md
Name: inj_local_port_arbiter

Overview:
- Shares one router Local input port between NUM_REQ injector PEs using the existing Req/Gnt/Full handshake.
- Each injector sees the arbiter as its downstream router. The router sees the arbiter as a single injector.
- Round-robin, one packet in flight at a time. The packet is latched at selection and held stable until the router grants.
- Sits between the per-node injector instances and the router Local port inside each mesh node.

Parameters:
- NUM_REQ, 4, number of injectors sharing the port (2..8).
- packetwidth, 56, packet bus width in bits.
- IDXW, 2, winner index width; must equal clog2(NUM_REQ), and at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ReqUpStr  input  NUM_REQ  per-injector send request; bit i belongs to injector i.
- PacketIn  input  NUM_REQ*packetwidth  injector packets; slice i is [i*packetwidth +: packetwidth].
- GntUpStr  output  NUM_REQ  one-hot grant back to the injectors.
- UpStrFull  output  1  buffer-full indication, broadcast to all injectors.
- ReqDnStr  output  1  request to the router Local port.
- GntDnStr  input  1  grant from the router Local port.
- DnStrFull  input  1  router Local FIFO full.
- PacketOut  output  packetwidth  packet to the router Local port.
- Winner  output  IDXW  index of the current or last granted requester.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset=0): state=IDLE, GntUpStr=0, ReqDnStr=0, PacketOut=0, Winner=0, round-robin pointer ptr=0, Busy=0. Reset mid-transaction aborts it and issues no grant.
- UpStrFull = DnStrFull, purely combinational.
- States: IDLE, WAIT_DN, GNT_UP.
- IDLE:
  - If (|ReqUpStr) and !DnStrFull: pick the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Then Winner<=idx, PacketOut<=slice idx, ReqDnStr<=1, state<=WAIT_DN.
  - Otherwise stay in IDLE with all outputs held.
- WAIT_DN:
  - ReqDnStr stays 1; PacketOut and Winner are frozen.
  - ReqUpStr changes and DnStrFull changes are ignored in this state.
  - On GntDnStr=1: ReqDnStr<=0, GntUpStr<=(1<<Winner), ptr<=(Winner+1) mod NUM_REQ, state<=GNT_UP.
- GNT_UP:
  - GntUpStr<=0 and state<=IDLE unconditionally, so every grant pulse is exactly 1 cycle.
  - This gives the winning injector one edge to drop its request before the next arbitration in IDLE.
- Latency:
  - Request sampled in IDLE at edge N → ReqDnStr high and PacketOut valid after edge N.
  - Router grant sampled at edge M → GntUpStr pulse after edge M, arbiter back in IDLE after edge M+1.
  - Best case: one packet per 3 cycles.
- Boundary cases:
  - DnStrFull=1 in IDLE blocks selection; ptr is unchanged.
  - A request dropped by the injector while in WAIT_DN still completes, and the grant is still pulsed.
  - GntDnStr=1 while in IDLE or GNT_UP is ignored.
  - Single requester: it wins back-to-back, with the 1-cycle GNT_UP gap between packets.
  - ptr wraps from NUM_REQ-1 to 0.
- Busy = (state != IDLE).

Test Plan:
- Reset, then ReqUpStr=4'b0000 for 10 cycles → ReqDnStr=0, GntUpStr=0, PacketOut=0, Busy=0 throughout.
- ReqUpStr=4'b0100, PacketIn slice 2=56'hABC, router grants 2 cycles after ReqDnStr rises → PacketOut=56'hABC, Winner=2, GntUpStr=4'b0100 for exactly 1 cycle, ptr=3.
- ReqUpStr held at 4'b1111, router grants immediately each time → grant order 0,1,2,3,0; consecutive ReqDnStr rises 3 cycles apart.
- DnStrFull=1 while ReqUpStr=4'b0010 for 5 cycles → no ReqDnStr, UpStrFull=1; DnStrFull=0 → ReqDnStr rises on the next edge with Winner=1.
- In WAIT_DN, change PacketIn slice 1 and raise ReqUpStr[3] → PacketOut unchanged until the grant; requester 3 is served only after the GNT_UP cycle.
- Assert reset=0 asynchronously mid-clock while in WAIT_DN → ReqDnStr=0 immediately, no GntUpStr pulse; after release, ptr=0 and arbitration restarts from requester 0.
